// File: rtl/result_handoff_if.sv
// Bundle of the eig_core result bus and the output_loader launch bus.
// slave: the handoff block; master: whoever drives the core/loader side.
interface result_handoff_if;
  logic               core_busy;
  logic signed [31:0] kappa;
  logic signed [31:0] inv_kappa;
  logic        [2:0]  regime;
  logic               ol_busy;
  logic               start_ol;
  logic signed [31:0] word_a;
  logic signed [31:0] word_b;
  logic        [2:0]  mode;

  modport slave (
    input  core_busy, kappa, inv_kappa, regime, ol_busy,
    output start_ol, word_a, word_b, mode
  );

  modport master (
    output core_busy, kappa, inv_kappa, regime, ol_busy,
    input  start_ol, word_a, word_b, mode
  );
endinterface

// File: rtl/result_handoff.sv
// Captures eig_core results on the falling edge of core_busy into a small
// FIFO and launches them one at a time into the output loader.
module result_handoff #(
  parameter int DEPTH       = 2,  // 2 or 4 records
  parameter int ACK_TIMEOUT = 4   // 1..15 cycles
) (
  input  logic                clk,
  input  logic                rst_n,
  result_handoff_if.slave     hif,
  input  logic                clr_i,
  output logic [2:0]          fill_o,
  output logic                overrun_o,
  output logic                ack_err_o,
  output logic [7:0]          drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
  } rec_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q;
  rec_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [2:0]      fill_q, fill_d;
  logic            start_q;
  rec_t            out_q;
  logic            overrun_q, ack_err_q;
  logic [7:0]      drop_q;

  logic capture, pop, full, drop, wr, timeout;
  rec_t in_rec;

  assign in_rec  = '{a: hif.kappa, b: hif.inv_kappa, m: hif.regime};
  assign capture = busy_q & ~hif.core_busy;
  // Pop only from IDLE; a record written this cycle is not yet visible in fill_q.
  assign pop     = (state_q == IDLE) && (fill_q != 3'd0) && !hif.ol_busy;
  assign full    = (fill_q == 3'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign drop    = capture && full && !pop;
  assign wr      = capture && !drop;

  // Launch FSM next-state, ack timeout counter and occupancy update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE:      if (pop) state_d = LAUNCH;
      LAUNCH: begin
        cnt_d   = 4'd0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (hif.ol_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == 4'(ACK_TIMEOUT)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_DONE: if (!hif.ol_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    unique case ({wr, pop})
      2'b10:   fill_d = fill_q + 3'd1;
      2'b01:   fill_d = fill_q - 3'd1;
      default: fill_d = fill_q;
    endcase
  end

  // FSM, pointers, held operands and registered launch pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= 3'd0;
      start_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= hif.core_busy;
      fill_q  <= fill_d;
      // Delayed one cycle from LAUNCH so the pulse comes straight off a flop.
      start_q <= (state_q == LAUNCH);
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        out_q    <= mem_q[rd_ptr_q];
      end
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= in_rec;
  end

  // Sticky error flags and saturating drop counter; a new event beats clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      ack_err_q <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      if (drop)       overrun_q <= 1'b1;
      else if (clr_i) overrun_q <= 1'b0;

      if (timeout)    ack_err_q <= 1'b1;
      else if (clr_i) ack_err_q <= 1'b0;

      if (drop) begin
        if (clr_i)              drop_q <= 8'd1;
        else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end else if (clr_i) begin
        drop_q <= 8'd0;
      end
    end
  end

  assign hif.start_ol = start_q;
  assign hif.word_a   = out_q.a;
  assign hif.word_b   = out_q.b;
  assign hif.mode     = out_q.m;
  assign fill_o       = fill_q;
  assign overrun_o    = overrun_q;
  assign ack_err_o    = ack_err_q;
  assign drop_cnt_o   = drop_q;

endmodule
